// File: rtl/micro_sequencer_pkg.sv
// Shared constants for the micro-PC sequencer: address-control codes,
// MIPS opcode/funct encodings and the micro-ROM dispatch entry points.
package micro_seq_pkg;

  localparam logic [2:0] AC_FETCH = 3'd0;
  localparam logic [2:0] AC_SEQ   = 3'd1;
  localparam logic [2:0] AC_DISP1 = 3'd2;
  localparam logic [2:0] AC_DISP2 = 3'd3;
  localparam logic [2:0] AC_JUMP  = 3'd4;
  localparam logic [2:0] AC_CJUMP = 3'd5;
  localparam logic [2:0] AC_CALL  = 3'd6;
  localparam logic [2:0] AC_RET   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [7:0] UA_MULT  = 8'h10;
  localparam logic [7:0] UA_NOR   = 8'h06;
  localparam logic [7:0] UA_SRAV  = 8'h0C;
  localparam logic [7:0] UA_SLT   = 8'h08;
  localparam logic [7:0] UA_JR    = 8'h03;
  localparam logic [7:0] UA_MFLO  = 8'h13;
  localparam logic [7:0] UA_ADDI  = 8'h0E;
  localparam logic [7:0] UA_XORI  = 8'h11;
  localparam logic [7:0] UA_SLTI  = 8'h0A;
  localparam logic [7:0] UA_BEQ   = 8'h04;
  localparam logic [7:0] UA_BGTZ  = 8'h05;
  localparam logic [7:0] UA_JAL   = 8'h02;
  localparam logic [7:0] UA_MEM1  = 8'h18;
  localparam logic [7:0] UA_LW2   = 8'h19;
  localparam logic [7:0] UA_SW2   = 8'h1C;

endpackage

// File: rtl/micro_sequencer_if.sv
// Instruction-field, micro-word control and micro-PC status bundle
// between the control unit (master) and the sequencer (slave).
interface micro_sequencer_if #(
  parameter int UPC_W = 8,
  parameter int OP_W  = 6,
  parameter int SP_W  = 3
);
  logic [OP_W-1:0]  i_op;
  logic [OP_W-1:0]  i_funct;
  logic [2:0]       i_addr_ctl;
  logic [UPC_W-1:0] i_target;
  logic             i_cond;
  logic             i_stall;
  logic [UPC_W-1:0] o_upc;
  logic             o_illegal;
  logic [SP_W-1:0]  o_sp;

  modport master (
    output i_op, i_funct, i_addr_ctl, i_target, i_cond, i_stall,
    input  o_upc, o_illegal, o_sp
  );

  modport slave (
    input  i_op, i_funct, i_addr_ctl, i_target, i_cond, i_stall,
    output o_upc, o_illegal, o_sp
  );
endinterface

// File: rtl/upc_dispatch_rom.sv
// Combinational two-level dispatch tables: table1 (opcode, or funct when
// opcode is R-type) and table2 (memory ops), each with a hit flag.
module upc_dispatch_rom
  import micro_seq_pkg::*;
#(
  parameter int UPC_W = 8,
  parameter int OP_W  = 6
) (
  input  logic [OP_W-1:0]  op,
  input  logic [OP_W-1:0]  funct,
  output logic [UPC_W-1:0] disp1_addr,
  output logic             disp1_hit,
  output logic [UPC_W-1:0] disp2_addr,
  output logic             disp2_hit
);

  // first-level dispatch; R-type decodes on funct
  always_comb begin
    disp1_addr = '0;
    disp1_hit  = 1'b1;
    if (op == OP_W'(OP_RTYPE)) begin
      case (funct)
        OP_W'(FN_MULT): disp1_addr = UPC_W'(UA_MULT);
        OP_W'(FN_NOR):  disp1_addr = UPC_W'(UA_NOR);
        OP_W'(FN_SRAV): disp1_addr = UPC_W'(UA_SRAV);
        OP_W'(FN_SLT):  disp1_addr = UPC_W'(UA_SLT);
        OP_W'(FN_JR):   disp1_addr = UPC_W'(UA_JR);
        OP_W'(FN_MFLO): disp1_addr = UPC_W'(UA_MFLO);
        default:        disp1_hit  = 1'b0;
      endcase
    end else begin
      case (op)
        OP_W'(OP_ADDI):               disp1_addr = UPC_W'(UA_ADDI);
        OP_W'(OP_XORI):               disp1_addr = UPC_W'(UA_XORI);
        OP_W'(OP_SLTI):               disp1_addr = UPC_W'(UA_SLTI);
        OP_W'(OP_BEQ):                disp1_addr = UPC_W'(UA_BEQ);
        OP_W'(OP_BGTZ):               disp1_addr = UPC_W'(UA_BGTZ);
        OP_W'(OP_JAL):                disp1_addr = UPC_W'(UA_JAL);
        OP_W'(OP_LW), OP_W'(OP_SW):   disp1_addr = UPC_W'(UA_MEM1);
        default:                      disp1_hit  = 1'b0;
      endcase
    end
  end

  // second-level dispatch for loads/stores
  always_comb begin
    disp2_addr = '0;
    disp2_hit  = 1'b1;
    case (op)
      OP_W'(OP_LW): disp2_addr = UPC_W'(UA_LW2);
      OP_W'(OP_SW): disp2_addr = UPC_W'(UA_SW2);
      default:      disp2_hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: next-address select, micro-PC and trap-pulse registers.
// Define MICRO_CALL_EN to add the micro-subroutine return stack (CALL/RET).
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int               UPC_W       = 8,
  parameter int               OP_W        = 6,
  parameter logic [UPC_W-1:0] TRAP_ADDR   = {UPC_W{1'b1}},
  parameter int               STACK_DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  micro_sequencer_if.slave  bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [UPC_W-1:0] upc_r;
  logic             illegal_r;
  logic [UPC_W-1:0] next_upc_s;
  logic [UPC_W-1:0] upc_inc_s;
  logic             trap_s;
  logic [UPC_W-1:0] disp1_addr_s;
  logic [UPC_W-1:0] disp2_addr_s;
  logic             disp1_hit_s;
  logic             disp2_hit_s;

  upc_dispatch_rom #(.UPC_W(UPC_W), .OP_W(OP_W)) u_rom (
    .op         (bus.i_op),
    .funct      (bus.i_funct),
    .disp1_addr (disp1_addr_s),
    .disp1_hit  (disp1_hit_s),
    .disp2_addr (disp2_addr_s),
    .disp2_hit  (disp2_hit_s)
  );

  assign upc_inc_s = upc_r + UPC_W'(1);

`ifdef MICRO_CALL_EN
  logic [UPC_W-1:0] stack_r [STACK_DEPTH];
  logic [SP_W-1:0]  sp_r;
  logic             push_s;
  logic             pop_s;
  logic [IDX_W-1:0] push_idx_s;
  logic [IDX_W-1:0] pop_idx_s;

  assign push_idx_s = IDX_W'(sp_r);
  assign pop_idx_s  = IDX_W'(sp_r - SP_W'(1));
`endif

  // next-address select; every illegal path lands on TRAP_ADDR
  always_comb begin
    next_upc_s = upc_r;
    trap_s     = 1'b0;
`ifdef MICRO_CALL_EN
    push_s     = 1'b0;
    pop_s      = 1'b0;
`endif
    case (bus.i_addr_ctl)
      AC_FETCH: next_upc_s = '0;
      AC_SEQ:   next_upc_s = upc_inc_s;
      AC_DISP1: if (disp1_hit_s) next_upc_s = disp1_addr_s;
                else begin trap_s = 1'b1; next_upc_s = TRAP_ADDR; end
      AC_DISP2: if (disp2_hit_s) next_upc_s = disp2_addr_s;
                else begin trap_s = 1'b1; next_upc_s = TRAP_ADDR; end
      AC_JUMP:  next_upc_s = bus.i_target;
      AC_CJUMP: if (bus.i_cond) next_upc_s = bus.i_target;
                else next_upc_s = upc_inc_s;
`ifdef MICRO_CALL_EN
      AC_CALL:  if (sp_r == SP_W'(STACK_DEPTH)) begin trap_s = 1'b1; next_upc_s = TRAP_ADDR; end
                else begin push_s = 1'b1; next_upc_s = bus.i_target; end
      AC_RET:   if (sp_r == '0) begin trap_s = 1'b1; next_upc_s = TRAP_ADDR; end
                else begin pop_s = 1'b1; next_upc_s = stack_r[pop_idx_s]; end
`endif
      default:  begin trap_s = 1'b1; next_upc_s = TRAP_ADDR; end
    endcase
  end

  // micro-PC and trap pulse; stall holds the PC and suppresses the pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      upc_r     <= '0;
      illegal_r <= 1'b0;
    end else if (bus.i_stall) begin
      illegal_r <= 1'b0;
    end else begin
      upc_r     <= next_upc_s;
      illegal_r <= trap_s;
    end
  end

`ifdef MICRO_CALL_EN
  // return stack; overflow/underflow traps leave it untouched
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sp_r <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_r[i] <= '0;
    end else if (!bus.i_stall && push_s) begin
      stack_r[push_idx_s] <= upc_inc_s;
      sp_r                <= sp_r + SP_W'(1);
    end else if (!bus.i_stall && pop_s) begin
      sp_r <= sp_r - SP_W'(1);
    end
  end

  assign bus.o_sp = sp_r;
`else
  assign bus.o_sp = '0;
`endif

  assign bus.o_upc     = upc_r;
  assign bus.o_illegal = illegal_r;

endmodule
